// File: rtl/vga_scan_timing.sv
// vga_scan_timing: VGA counters, latency-matched blanking/sync delay line and frame strobes.
module vga_scan_timing #(
  parameter int H_VISIBLE     = 800,
  parameter int H_FRONT       = 56,
  parameter int H_SYNC        = 120,
  parameter int H_BACK        = 64,
  parameter int V_VISIBLE     = 600,
  parameter int V_FRONT       = 37,
  parameter int V_SYNC        = 6,
  parameter int V_BACK        = 23,
  parameter bit HSYNC_POL     = 1'b1,
  parameter bit VSYNC_POL     = 1'b1,
  parameter int PIXEL_LATENCY = 1
) (
  input  logic        VGA_CLOCK,
  input  logic        RESET,
  input  logic [2:0]  PIXEL_IN,
  output logic [10:0] PIXEL_H,
  output logic [10:0] PIXEL_V,
  output logic        VGA_R,
  output logic        VGA_G,
  output logic        VGA_B,
  output logic        VGA_HSYNC,
  output logic        VGA_VSYNC,
  output logic        FRAME_START,
  output logic [7:0]  FRAME_COUNT
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int L = PIXEL_LATENCY;
  logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic [L-1:0][2:0] dly_q, dly_d;
  logic [L:0][2:0] dly_sh;
  logic [2:0] dly_out, rgb_q, rgb_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic h_wrap, v_wrap, active, hs, vs;
  always_comb begin
    h_wrap = h_cnt_q == 11'(H_TOTAL - 1);
    v_wrap = v_cnt_q == 11'(V_TOTAL - 1);
    h_cnt_d = h_wrap ? 11'd0 : h_cnt_q + 11'd1;
    v_cnt_d = h_wrap ? (v_wrap ? 11'd0 : v_cnt_q + 11'd1) : v_cnt_q;
    frame_count_d = frame_count_q + {7'd0, h_wrap & v_wrap};
    active = (h_cnt_q < 11'(H_VISIBLE)) && (v_cnt_q < 11'(V_VISIBLE));
    hs = (h_cnt_q >= 11'(H_VISIBLE + H_FRONT)) && (h_cnt_q < 11'(H_VISIBLE + H_FRONT + H_SYNC));
    vs = (v_cnt_q >= 11'(V_VISIBLE + V_FRONT)) && (v_cnt_q < 11'(V_VISIBLE + V_FRONT + V_SYNC));
    // {active, hs, vs} ride the same shift register so colour and sync stay pixel-aligned
    dly_sh = {dly_q, {active, hs, vs}};
    dly_d = dly_sh[L-1:0];
    dly_out = dly_q[L-1];
    rgb_d = dly_out[2] ? PIXEL_IN : 3'd0;
    hsync_d = dly_out[1] ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = dly_out[0] ? VSYNC_POL : ~VSYNC_POL;
  end
  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      frame_count_q <= '0;
      dly_q <= '0;
      rgb_q <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      frame_count_q <= frame_count_d;
      dly_q <= dly_d;
      rgb_q <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end
  assign PIXEL_H = h_cnt_q;
  assign PIXEL_V = v_cnt_q;
  assign {VGA_R, VGA_G, VGA_B} = rgb_q;
  assign VGA_HSYNC = hsync_q;
  assign VGA_VSYNC = vsync_q;
  assign FRAME_START = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
  assign FRAME_COUNT = frame_count_q;
endmodule

// File: tb/tb_vga_scan_timing.sv
// tb_vga_scan_timing: scoreboard bench on a shrunken 15x8 raster, latency 1 and latency 3 instances.
module tb_vga_scan_timing;
  localparam int HV = 8, HF = 2, HSW = 3, HB = 2, HT = 15;
  localparam int VV = 4, VF = 1, VSW = 2, VB = 1, VT = 8;
  localparam int FR = HT * VT;
  typedef struct {int e; int sel; int exp;} item_t;
  logic clk = 0, RESET = 1;
  logic [2:0] pin_a = 0, pin_b = 0;
  logic [10:0] ha, va, hb, vb;
  logic ra, ga, ba, hsa, vsa, fsa, rb, gb, bb, hsb, vsb, fsb;
  logic [7:0] fca, fcb;
  int ecnt = 0, errors = 0, checks = 0, rcnt = 0;
  item_t q[$];
  item_t tbl[$];
  string names[13] = '{"a_h", "a_v", "a_hsync", "a_vsync", "a_rgb", "a_fstart", "a_fcount",
                       "b_hsync", "b_vsync", "b_rgb", "b_fstart", "b_fcount", "a_rcount"};
  vga_scan_timing #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB), .PIXEL_LATENCY(1)) dut_a (
    .VGA_CLOCK(clk), .RESET(RESET), .PIXEL_IN(pin_a), .PIXEL_H(ha), .PIXEL_V(va),
    .VGA_R(ra), .VGA_G(ga), .VGA_B(ba), .VGA_HSYNC(hsa), .VGA_VSYNC(vsa),
    .FRAME_START(fsa), .FRAME_COUNT(fca));
  vga_scan_timing #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB), .HSYNC_POL(1'b0),
    .PIXEL_LATENCY(3)) dut_b (
    .VGA_CLOCK(clk), .RESET(RESET), .PIXEL_IN(pin_b), .PIXEL_H(hb), .PIXEL_V(vb),
    .VGA_R(rb), .VGA_G(gb), .VGA_B(bb), .VGA_HSYNC(hsb), .VGA_VSYNC(vsb),
    .FRAME_START(fsb), .FRAME_COUNT(fcb));
  always #5 clk = ~clk;
  always @(posedge clk or posedge RESET) ecnt <= RESET ? 0 : ecnt + 1;
  function automatic int mode_of(int c);
    return c < 2 * FR ? 0 : c < 3 * FR ? 1 : 2;
  endfunction
  function automatic int pin(int e, int l, int kind, int hp, int vp);
    int c, h, v, m;
    c = e - l - 1;
    if (c < 0) return kind == 0 ? 1 - hp : kind == 1 ? 1 - vp : 0;
    h = c % HT;
    v = (c / HT) % VT;
    m = mode_of(c);
    if (kind == 0) return (h >= HV + HF && h < HV + HF + HSW) ? hp : 1 - hp;
    if (kind == 1) return (v >= VV + VF && v < VV + VF + VSW) ? vp : 1 - vp;
    if (!(h < HV && v < VV)) return 0;
    return m == 0 ? 7 : m == 1 ? 0 : 4 * int'(h == 0) + 2 * int'(h == HV - 1) + int'(v == VV - 1);
  endfunction
  function automatic int expv(int e, int sel);
    case (sel)
      0: return e % HT;
      1: return (e / HT) % VT;
      2: return pin(e, 1, 0, 1, 1);
      3: return pin(e, 1, 1, 1, 1);
      4: return pin(e, 1, 2, 1, 1);
      7: return pin(e, 3, 0, 0, 1);
      8: return pin(e, 3, 1, 0, 1);
      9: return pin(e, 3, 2, 0, 1);
      5, 10: return int'(e % FR == 0);
      default: return (e / FR) % 256;
    endcase
  endfunction
  function automatic int got(int sel);
    case (sel)
      0: return int'(ha);
      1: return int'(va);
      2: return int'(hsa);
      3: return int'(vsa);
      4: return int'({ra, ga, ba});
      5: return int'(fsa);
      6: return int'(fca);
      7: return int'(hsb);
      8: return int'(vsb);
      9: return int'({rb, gb, bb});
      10: return int'(fsb);
      11: return int'(fcb);
      default: return rcnt;
    endcase
  endfunction
  function automatic logic [2:0] drive(int m, logic [10:0] h, logic [10:0] v);
    return m == 0 ? 3'b111 : m == 1 ? 3'b000 : {h == 11'd0, h == 11'(HV - 1), v == 11'(VV - 1)};
  endfunction
  // PIXEL_IN in cycle c carries the pattern for the coordinates L cycles earlier
  initial begin
    logic [2:0] hist_a [4];
    logic [2:0] hist_b [4];
    for (int i = 0; i < 4; i++) begin
      hist_a[i] = 0;
      hist_b[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 3; i > 0; i--) begin
        hist_a[i] = hist_a[i-1];
        hist_b[i] = hist_b[i-1];
      end
      hist_a[0] = drive(mode_of(ecnt), ha, va);
      hist_b[0] = drive(mode_of(ecnt), hb, vb);
      pin_a = hist_a[1];
      pin_b = hist_b[3];
    end
  end
  initial begin
    item_t it;
    int g;
    forever begin
      @(negedge clk);
      if (RESET) rcnt = 0;
      else if (ecnt >= 2 && ecnt < FR + 2 && ra) rcnt++;
      while (q.size() != 0 && q[0].e <= ecnt) begin
        it = q.pop_front();
        g = it.e < ecnt ? -1 : got(it.sel);
        checks++;
        if (g != it.exp) begin
          errors++;
          $display("FAIL %s at edge %0d: got %0d expected %0d", names[it.sel], it.e, g, it.exp);
        end
      end
    end
  end
  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic push(int e, int sel, int exp);
    item_t it;
    it.e = e;
    it.sel = sel;
    it.exp = exp;
    q.push_back(it);
  endtask
  initial begin
    tbl = '{'{5, 4, 7}, '{11, 2, 0}, '{12, 2, 1}, '{13, 7, 1}, '{14, 2, 1}, '{14, 7, 0},
            '{15, 2, 0}, '{16, 7, 0}, '{17, 7, 1}, '{27, 2, 1}, '{76, 3, 0}, '{77, 3, 1},
            '{106, 3, 1}, '{107, 3, 0}, '{119, 6, 0}, '{120, 5, 1}, '{120, 6, 1}, '{122, 12, 32},
            '{245, 4, 0}, '{362, 4, 4}, '{364, 9, 4}, '{369, 4, 2}, '{370, 4, 0}, '{371, 9, 2},
            '{407, 4, 5}, '{409, 9, 5}, '{414, 4, 3}};
    repeat (3) @(negedge clk);
    RESET = 0;
    for (int i = 0; i < 100 && ecnt != 2 * HT + 5; i++) @(negedge clk);
    check("pre_reset_h", int'(ha), 5);
    check("pre_reset_v", int'(va), 2);
    #2 RESET = 1;
    #1;
    check("rst_h", int'(ha), 0);
    check("rst_v", int'(va), 0);
    check("rst_rgb", int'({ra, ga, ba}), 0);
    check("rst_hsync_a", int'(hsa), 0);
    check("rst_vsync_a", int'(vsa), 0);
    check("rst_hsync_b", int'(hsb), 1);
    check("rst_fstart", int'(fsa), 1);
    check("rst_fcount", int'(fca), 0);
    repeat (3) @(negedge clk);
    RESET = 0;
    for (int e = 1; e <= 4 * FR; e++) begin
      for (int s = 0; s < 12; s++) push(e, s, expv(e, s));
      foreach (tbl[i]) if (tbl[i].e == e) q.push_back(tbl[i]);
    end
    for (int n = 5; n <= 256; n++) begin
      push(n * FR - 1, 5, 0);
      push(n * FR - 1, 6, n - 1);
      push(n * FR, 5, 1);
      push(n * FR, 6, n % 256);
      push(n * FR, 11, n % 256);
    end
    for (int i = 0; i < 257 * FR && q.size() != 0; i++) @(negedge clk);
    #1 check("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
